// File: rtl/axi4_burst_mem_slave_pkg.sv
// Shared AXI4 constants and FSM state types for the burst memory slave.
// Optional random stalls are enabled by defining AXI4_SLAVE_RAND_STALL_EN.
package ysyx_040729_axi_pkg;

  typedef logic [1:0] axi_burst_t;
  typedef logic [1:0] axi_resp_t;

  localparam axi_burst_t BURST_FIXED = 2'b00;
  localparam axi_burst_t BURST_INCR  = 2'b01;
  localparam axi_burst_t BURST_WRAP  = 2'b10;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_BEAT
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 AW/W/B/AR/R bundle between the core master and the burst memory.
// Suffixes _i/_o are from the slave's point of view.
interface axi4_burst_mem_slave_if #(
  parameter int AW  = 32,
  parameter int IDW = 4,
  parameter int UW  = 1,
  parameter int DW  = 64
);
  logic           axi_aw_valid_i;
  logic [AW-1:0]  axi_aw_addr_i;
  logic [IDW-1:0] axi_aw_id_i;
  logic [7:0]     axi_aw_len_i;
  logic [2:0]     axi_aw_size_i;
  logic [1:0]     axi_aw_burst_i;
  logic           axi_aw_ready_o;

  logic            axi_w_valid_i;
  logic [DW-1:0]   axi_w_data_i;
  logic [DW/8-1:0] axi_w_strb_i;
  logic            axi_w_last_i;
  logic            axi_w_ready_o;

  logic           axi_b_valid_o;
  logic [1:0]     axi_b_resp_o;
  logic [IDW-1:0] axi_b_id_o;
  logic [UW-1:0]  axi_b_user_o;
  logic           axi_b_ready_i;

  logic           axi_ar_valid_i;
  logic [AW-1:0]  axi_ar_addr_i;
  logic [IDW-1:0] axi_ar_id_i;
  logic [7:0]     axi_ar_len_i;
  logic [2:0]     axi_ar_size_i;
  logic [1:0]     axi_ar_burst_i;
  logic           axi_ar_ready_o;

  logic           axi_r_valid_o;
  logic [DW-1:0]  axi_r_data_o;
  logic [1:0]     axi_r_resp_o;
  logic           axi_r_last_o;
  logic [IDW-1:0] axi_r_id_o;
  logic [UW-1:0]  axi_r_user_o;
  logic           axi_r_ready_i;

  modport slave (
    input  axi_aw_valid_i, axi_aw_addr_i, axi_aw_id_i,
    input  axi_aw_len_i, axi_aw_size_i, axi_aw_burst_i,
    output axi_aw_ready_o,
    input  axi_w_valid_i, axi_w_data_i, axi_w_strb_i,
    input  axi_w_last_i,
    output axi_w_ready_o,
    output axi_b_valid_o, axi_b_resp_o, axi_b_id_o,
    output axi_b_user_o,
    input  axi_b_ready_i,
    input  axi_ar_valid_i, axi_ar_addr_i, axi_ar_id_i,
    input  axi_ar_len_i, axi_ar_size_i, axi_ar_burst_i,
    output axi_ar_ready_o,
    output axi_r_valid_o, axi_r_data_o, axi_r_resp_o,
    output axi_r_last_o, axi_r_id_o, axi_r_user_o,
    input  axi_r_ready_i
  );

  modport master (
    output axi_aw_valid_i, axi_aw_addr_i, axi_aw_id_i,
    output axi_aw_len_i, axi_aw_size_i, axi_aw_burst_i,
    input  axi_aw_ready_o,
    output axi_w_valid_i, axi_w_data_i, axi_w_strb_i,
    output axi_w_last_i,
    input  axi_w_ready_o,
    input  axi_b_valid_o, axi_b_resp_o, axi_b_id_o,
    input  axi_b_user_o,
    output axi_b_ready_i,
    output axi_ar_valid_i, axi_ar_addr_i, axi_ar_id_i,
    output axi_ar_len_i, axi_ar_size_i, axi_ar_burst_i,
    input  axi_ar_ready_o,
    input  axi_r_valid_o, axi_r_data_o, axi_r_resp_o,
    input  axi_r_last_o, axi_r_id_o, axi_r_user_o,
    output axi_r_ready_i
  );
endinterface

// File: rtl/axi4_burst_mem_slave_addr_gen.sv
// Per-channel burst address/beat tracker with range and mode checking.
// Produces the word index into the backing array for the current beat.
module axi_burst_addr_gen
  import ysyx_040729_axi_pkg::*;
#(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE      = 32'h8000_0000,
  parameter int            MEM_WORDS = 65536,
  parameter int            IW        = $clog2(MEM_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_load,
  input  logic [AW-1:0] i_addr,
  input  logic [2:0]    i_size,
  input  axi_burst_t    i_burst,
  input  logic [7:0]    i_len,
  input  logic          i_advance,
  output logic [AW-1:0] o_cur_addr,
  output logic [7:0]    o_beat_cnt,
  output logic          o_last,
  output logic          o_err,
  output logic [IW-1:0] o_idx
);
  logic [AW-1:0] r_addr;
  logic [7:0]    r_cnt;
  logic [7:0]    r_len;
  logic [2:0]    r_size;
  axi_burst_t    r_burst;

  logic [AW-1:0] w_step;
  logic [AW-4:0] w_off;
  logic          w_oor;
  logic          w_bad_mode;

  assign w_step = {{(AW-1){1'b0}}, 1'b1} << r_size;
  // Word offset wraps modulo 2^(AW-3), so below-base lands far out of range.
  assign w_off  = r_addr[AW-1:3] - BASE[AW-1:3];
  assign w_oor  = w_off >= (AW-3)'(MEM_WORDS);
  assign w_bad_mode = (r_burst == BURST_WRAP) ||
                      (r_size > 3'd3);

  assign o_cur_addr = r_addr;
  assign o_beat_cnt = r_cnt;
  assign o_last     = r_cnt == r_len;
  assign o_err      = w_oor | w_bad_mode;
  assign o_idx      = w_off[IW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= BURST_FIXED;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_cnt   <= '0;
      r_len   <= i_len;
      r_size  <= i_size;
      r_burst <= i_burst;
    end else if (i_advance) begin
      r_cnt <= r_cnt + 8'd1;
      if (r_burst != BURST_FIXED)
        r_addr <= r_addr + w_step;
    end
  end
endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave: independent read/write FSMs over a 64-bit array.
// Define AXI4_SLAVE_RAND_STALL_EN to add LFSR-driven handshake stalls.
module axi4_burst_mem_slave
  import ysyx_040729_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int MEM_WORDS      = 65536
) (
  input logic clock,
  input logic reset,
  axi4_burst_mem_slave_if.slave s_axi
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int AW = AXI_ADDR_WIDTH;

  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  rd_state_e r_rstate, w_rstate_nxt;
  wr_state_e r_wstate, w_wstate_nxt;

  logic [AXI_ID_WIDTH-1:0] r_rid;
  logic [AXI_ID_WIDTH-1:0] r_bid;
  logic                    r_berr;

  logic w_ar_ready, w_aw_ready, w_w_ready;
  logic w_r_valid, w_b_valid;
  logic w_ar_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;
  logic w_ar_go, w_aw_go, w_w_go, w_r_go;

  logic [AW-1:0] w_rd_cur, w_wr_cur;
  logic [7:0]    w_rd_cnt, w_wr_cnt;
  logic          w_rd_last, w_wr_last;
  logic          w_rd_err, w_wr_err;
  logic [IW-1:0] w_rd_idx, w_wr_idx;
  logic          w_unused;

  assign w_unused = ^{w_rd_cur, w_wr_cur, w_rd_cnt, w_wr_cnt};

`ifdef AXI4_SLAVE_RAND_STALL_EN
  logic [15:0] r_lfsr;
  logic        r_rshow;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr  <= 16'hACE1;
      r_rshow <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0],
                 r_lfsr[15] ^ r_lfsr[13] ^
                 r_lfsr[12] ^ r_lfsr[10]};
      // A presented R beat must stay up until it is taken.
      if (w_r_hs)
        r_rshow <= 1'b0;
      else if (w_r_valid)
        r_rshow <= 1'b1;
    end
  end

  assign w_ar_go = r_lfsr[0];
  assign w_aw_go = r_lfsr[5];
  assign w_w_go  = r_lfsr[9];
  assign w_r_go  = r_lfsr[13] | r_rshow;
`else
  assign w_ar_go = 1'b1;
  assign w_aw_go = 1'b1;
  assign w_w_go  = 1'b1;
  assign w_r_go  = 1'b1;
`endif

  assign w_ar_hs = s_axi.axi_ar_valid_i & w_ar_ready;
  assign w_r_hs  = w_r_valid & s_axi.axi_r_ready_i;
  assign w_aw_hs = s_axi.axi_aw_valid_i & w_aw_ready;
  assign w_w_hs  = s_axi.axi_w_valid_i & w_w_ready;
  assign w_b_hs  = w_b_valid & s_axi.axi_b_ready_i;

  axi_burst_addr_gen #(
    .AW(AW), .BASE(BASE_ADDR),
    .MEM_WORDS(MEM_WORDS), .IW(IW)
  ) u_rd_gen (
    .clock(clock), .reset(reset),
    .i_load(w_ar_hs),
    .i_addr(s_axi.axi_ar_addr_i),
    .i_size(s_axi.axi_ar_size_i),
    .i_burst(s_axi.axi_ar_burst_i),
    .i_len(s_axi.axi_ar_len_i),
    .i_advance(w_r_hs),
    .o_cur_addr(w_rd_cur), .o_beat_cnt(w_rd_cnt),
    .o_last(w_rd_last), .o_err(w_rd_err),
    .o_idx(w_rd_idx)
  );

  axi_burst_addr_gen #(
    .AW(AW), .BASE(BASE_ADDR),
    .MEM_WORDS(MEM_WORDS), .IW(IW)
  ) u_wr_gen (
    .clock(clock), .reset(reset),
    .i_load(w_aw_hs),
    .i_addr(s_axi.axi_aw_addr_i),
    .i_size(s_axi.axi_aw_size_i),
    .i_burst(s_axi.axi_aw_burst_i),
    .i_len(s_axi.axi_aw_len_i),
    .i_advance(w_w_hs),
    .o_cur_addr(w_wr_cur), .o_beat_cnt(w_wr_cnt),
    .o_last(w_wr_last), .o_err(w_wr_err),
    .o_idx(w_wr_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
      r_rid    <= '0;
      r_bid    <= '0;
      r_berr   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_wstate <= w_wstate_nxt;
      if (w_ar_hs)
        r_rid <= s_axi.axi_ar_id_i;
      if (w_aw_hs) begin
        r_bid  <= s_axi.axi_aw_id_i;
        r_berr <= 1'b0;
      end else if (w_w_hs) begin
        r_berr <= r_berr | w_wr_err |
                  (s_axi.axi_w_last_i != w_wr_last);
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ar_ready   = 1'b0;
    w_r_valid    = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        w_ar_ready = !reset && w_ar_go;
        if (w_ar_hs) w_rstate_nxt = R_BEAT;
      end
      R_BEAT: begin
        w_r_valid = !reset && w_r_go;
        if (w_r_hs && w_rd_last) w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_ready   = 1'b0;
    w_w_ready    = 1'b0;
    w_b_valid    = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_aw_ready = !reset && w_aw_go;
        if (w_aw_hs) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        w_w_ready = !reset && w_w_go;
        if (w_w_hs && w_wr_last) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        w_b_valid = !reset;
        if (w_b_hs) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_w_hs && !w_wr_err) begin
      for (int b = 0; b < SW; b++) begin
        if (s_axi.axi_w_strb_i[b])
          r_mem[w_wr_idx][8*b +: 8] <= s_axi.axi_w_data_i[8*b +: 8];
      end
    end
  end

  assign s_axi.axi_ar_ready_o = w_ar_ready;
  assign s_axi.axi_r_valid_o  = w_r_valid;
  assign s_axi.axi_r_data_o   = (w_r_valid && !w_rd_err) ?
                                r_mem[w_rd_idx] : '0;
  assign s_axi.axi_r_resp_o   = (w_r_valid && w_rd_err) ?
                                RESP_SLVERR : RESP_OKAY;
  assign s_axi.axi_r_last_o   = w_r_valid & w_rd_last;
  assign s_axi.axi_r_id_o     = w_r_valid ? r_rid : '0;
  assign s_axi.axi_r_user_o   = '0;

  assign s_axi.axi_aw_ready_o = w_aw_ready;
  assign s_axi.axi_w_ready_o  = w_w_ready;
  assign s_axi.axi_b_valid_o  = w_b_valid;
  assign s_axi.axi_b_resp_o   = (w_b_valid && r_berr) ?
                                RESP_SLVERR : RESP_OKAY;
  assign s_axi.axi_b_id_o     = w_b_valid ? r_bid : '0;
  assign s_axi.axi_b_user_o   = '0;
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave: vector table plus burst,
// stall, reset and read/write collision sequences.
module tb_axi4_burst_mem_slave;
  import ysyx_040729_axi_pkg::*;

  localparam int TMO = 50;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  axi4_burst_mem_slave_if #(
    .AW(32), .IDW(4), .UW(1), .DW(64)
  ) bus ();

  axi4_burst_mem_slave #(
    .AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32),
    .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1),
    .BASE_ADDR(32'h8000_0000), .MEM_WORDS(65536)
  ) dut (
    .clock(clk),
    .reset(rst),
    .s_axi(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim still running, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] waddr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [31:0] raddr;
    logic [63:0] exp_data;
    logic [1:0]  exp_b;
    logic [1:0]  exp_r;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no handshake expected one in %0d cycles",
             nm, TMO);
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu);
    bit ok;
    ok = 0;
    bus.axi_ar_valid_i = 1'b1;
    bus.axi_ar_addr_i  = a;
    bus.axi_ar_id_i    = id;
    bus.axi_ar_len_i   = len;
    bus.axi_ar_size_i  = sz;
    bus.axi_ar_burst_i = bu;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      if (bus.axi_ar_ready_o) begin ok = 1; break; end
    end
    if (!ok) tmo("ar_hs");
    @(posedge clk); #1;
    bus.axi_ar_valid_i = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu);
    bit ok;
    ok = 0;
    bus.axi_aw_valid_i = 1'b1;
    bus.axi_aw_addr_i  = a;
    bus.axi_aw_id_i    = id;
    bus.axi_aw_len_i   = len;
    bus.axi_aw_size_i  = sz;
    bus.axi_aw_burst_i = bu;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      if (bus.axi_aw_ready_o) begin ok = 1; break; end
    end
    if (!ok) tmo("aw_hs");
    @(posedge clk); #1;
    bus.axi_aw_valid_i = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s,
                        input logic l);
    bit ok;
    ok = 0;
    bus.axi_w_valid_i = 1'b1;
    bus.axi_w_data_i  = d;
    bus.axi_w_strb_i  = s;
    bus.axi_w_last_i  = l;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      if (bus.axi_w_ready_o) begin ok = 1; break; end
    end
    if (!ok) tmo("w_hs");
    @(posedge clk); #1;
    bus.axi_w_valid_i = 1'b0;
  endtask

  task automatic b_get(input logic [1:0] er, input logic [3:0] id,
                       input string nm);
    bit ok;
    ok = 0;
    bus.axi_b_ready_i = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      if (bus.axi_b_valid_o) begin ok = 1; break; end
    end
    if (!ok) tmo({nm, "_b_hs"});
    else begin
      chk({nm, "_bresp"}, 64'(bus.axi_b_resp_o), 64'(er));
      chk({nm, "_bid"}, 64'(bus.axi_b_id_o), 64'(id));
    end
    @(posedge clk); #1;
    bus.axi_b_ready_i = 1'b0;
  endtask

  task automatic r_get(input logic [63:0] ed, input logic [1:0] er,
                       input logic el, input logic [3:0] id,
                       input string nm);
    bit ok;
    ok = 0;
    bus.axi_r_ready_i = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      if (bus.axi_r_valid_o) begin ok = 1; break; end
    end
    if (!ok) tmo({nm, "_r_hs"});
    else begin
      chk({nm, "_data"}, bus.axi_r_data_o, ed);
      chk({nm, "_resp"}, 64'(bus.axi_r_resp_o), 64'(er));
      chk({nm, "_last"}, 64'(bus.axi_r_last_o), 64'(el));
      chk({nm, "_id"}, 64'(bus.axi_r_id_o), 64'(id));
    end
    @(posedge clk); #1;
    bus.axi_r_ready_i = 1'b0;
  endtask

  task automatic wr_single(input logic [31:0] a, input logic [3:0] id,
                           input logic [63:0] d, input logic [7:0] s,
                           input logic [1:0] bu, input logic [2:0] sz,
                           input logic [1:0] eb, input string nm);
    aw_send(a, id, 8'd0, sz, bu);
    w_send(d, s, 1'b1);
    b_get(eb, id, nm);
  endtask

  task automatic rd_single(input logic [31:0] a, input logic [3:0] id,
                           input logic [63:0] ed, input logic [1:0] er,
                           input string nm);
    ar_send(a, id, 8'd0, 3'd3, BURST_INCR);
    r_get(ed, er, 1'b1, id, nm);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.axi_aw_valid_i = 0; bus.axi_aw_addr_i = 0;
    bus.axi_aw_id_i = 0; bus.axi_aw_len_i = 0;
    bus.axi_aw_size_i = 0; bus.axi_aw_burst_i = 0;
    bus.axi_w_valid_i = 0; bus.axi_w_data_i = 0;
    bus.axi_w_strb_i = 0; bus.axi_w_last_i = 0;
    bus.axi_b_ready_i = 0;
    bus.axi_ar_valid_i = 0; bus.axi_ar_addr_i = 0;
    bus.axi_ar_id_i = 0; bus.axi_ar_len_i = 0;
    bus.axi_ar_size_i = 0; bus.axi_ar_burst_i = 0;
    bus.axi_r_ready_i = 0;

    vt[0] = '{32'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF,
              BURST_INCR, 3'd3, 32'h8000_0000,
              64'h0123_4567_89AB_CDEF, RESP_OKAY, RESP_OKAY};
    vt[1] = '{32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788,
              BURST_INCR, 3'd3, 32'h8000_0010,
              64'h1122_3344_5566_7788, RESP_OKAY, RESP_OKAY};
    vt[2] = '{32'h8000_0020, 8'hFF, 64'h0,
              BURST_INCR, 3'd3, 32'h8000_0020,
              64'h0, RESP_OKAY, RESP_OKAY};
    vt[3] = '{32'h8000_0020, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF,
              BURST_INCR, 3'd3, 32'h8000_0020,
              64'h0000_0000_FFFF_FFFF, RESP_OKAY, RESP_OKAY};
    vt[4] = '{32'h8000_0204, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF,
              BURST_INCR, 3'd3, 32'h8000_0200,
              64'hCAFE_F00D_DEAD_BEEF, RESP_OKAY, RESP_OKAY};
    vt[5] = '{32'h8000_0020, 8'hFF, 64'h5555_5555_5555_5555,
              BURST_WRAP, 3'd3, 32'h8000_0020,
              64'h0000_0000_FFFF_FFFF, RESP_SLVERR, RESP_OKAY};
    vt[6] = '{32'h8000_0020, 8'hFF, 64'h6666_6666_6666_6666,
              BURST_INCR, 3'd4, 32'h8000_0020,
              64'h0000_0000_FFFF_FFFF, RESP_SLVERR, RESP_OKAY};
    vt[7] = '{32'h7FFF_FFF8, 8'hFF, 64'h7777_7777_7777_7777,
              BURST_INCR, 3'd3, 32'h7FFF_FFF8,
              64'h0, RESP_SLVERR, RESP_SLVERR};
    vt[8] = '{32'h8008_0000, 8'hFF, 64'h8888_8888_8888_8888,
              BURST_INCR, 3'd3, 32'h8008_0000,
              64'h0, RESP_SLVERR, RESP_SLVERR};
    vt[9] = '{32'h8007_FFF8, 8'hFF, 64'h9999_9999_9999_9999,
              BURST_INCR, 3'd3, 32'h8007_FFF8,
              64'h9999_9999_9999_9999, RESP_OKAY, RESP_OKAY};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_ready", 64'(bus.axi_ar_ready_o), 64'd0);
    chk("rst_aw_ready", 64'(bus.axi_aw_ready_o), 64'd0);
    chk("rst_w_ready", 64'(bus.axi_w_ready_o), 64'd0);
    chk("rst_r_valid", 64'(bus.axi_r_valid_o), 64'd0);
    chk("rst_b_valid", 64'(bus.axi_b_valid_o), 64'd0);
    chk("rst_r_data", bus.axi_r_data_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ar_ready", 64'(bus.axi_ar_ready_o), 64'd1);
    chk("idle_aw_ready", 64'(bus.axi_aw_ready_o), 64'd1);
    chk("idle_w_ready", 64'(bus.axi_w_ready_o), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      wr_single(vt[i].waddr, 4'(i), vt[i].wdata, vt[i].strb,
                vt[i].burst, vt[i].size, vt[i].exp_b,
                $sformatf("v%0d_w", i));
      rd_single(vt[i].raddr, 4'(i + 1), vt[i].exp_data,
                vt[i].exp_r, $sformatf("v%0d_r", i));
    end

    // Single read: data on the very next cycle after AR
    ar_send(32'h8000_0010, 4'h5, 8'd0, 3'd3, BURST_INCR);
    @(negedge clk);
    chk("t1_lat_valid", 64'(bus.axi_r_valid_o), 64'd1);
    chk("t1_data", bus.axi_r_data_o, 64'h1122_3344_5566_7788);
    chk("t1_last", 64'(bus.axi_r_last_o), 64'd1);
    chk("t1_resp", 64'(bus.axi_r_resp_o), 64'(RESP_OKAY));
    chk("t1_id", 64'(bus.axi_r_id_o), 64'h5);
    bus.axi_r_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.axi_r_ready_i = 1'b0;
    @(negedge clk);
    chk("t1_after_valid", 64'(bus.axi_r_valid_o), 64'd0);
    chk("t1_after_ar_ready", 64'(bus.axi_ar_ready_o), 64'd1);
    @(posedge clk); #1;

    // INCR burst write then read back
    aw_send(32'h8000_0100, 4'h1, 8'd3, 3'd3, BURST_INCR);
    for (int j = 0; j < 4; j++)
      w_send(64'(j), 8'hFF, j == 3);
    b_get(RESP_OKAY, 4'h1, "t2_w");
    ar_send(32'h8000_0100, 4'h2, 8'd3, 3'd3, BURST_INCR);
    for (int j = 0; j < 4; j++)
      r_get(64'(j), RESP_OKAY, j == 3, 4'h2,
            $sformatf("t2_r%0d", j));

    // Out-of-range first beat, wraps into the base word
    ar_send(32'h7FFF_FFF8, 4'h8, 8'd1, 3'd3, BURST_INCR);
    r_get(64'h0, RESP_SLVERR, 1'b0, 4'h8, "t4_b0");
    r_get(64'h0123_4567_89AB_CDEF, RESP_OKAY, 1'b1, 4'h8, "t4_b1");

    // FIXED burst write and read stay on one word
    aw_send(32'h8000_0300, 4'h9, 8'd1, 3'd3, BURST_FIXED);
    w_send(64'hAA, 8'hFF, 1'b0);
    w_send(64'hBB, 8'hFF, 1'b1);
    b_get(RESP_OKAY, 4'h9, "fx_w");
    ar_send(32'h8000_0300, 4'hA, 8'd1, 3'd3, BURST_FIXED);
    r_get(64'hBB, RESP_OKAY, 1'b0, 4'hA, "fx_r0");
    r_get(64'hBB, RESP_OKAY, 1'b1, 4'hA, "fx_r1");

    // Early w_last: SLVERR but beat count still ends the burst
    aw_send(32'h8000_0400, 4'hB, 8'd1, 3'd3, BURST_INCR);
    w_send(64'h1, 8'hFF, 1'b1);
    w_send(64'h2, 8'hFF, 1'b0);
    b_get(RESP_SLVERR, 4'hB, "wl_w");
    rd_single(32'h8000_0408, 4'hC, 64'h2, RESP_OKAY, "wl_r");

    // Backpressure hold, then reset mid-burst
    ar_send(32'h8000_0100, 4'h2, 8'd3, 3'd3, BURST_INCR);
    r_get(64'h0, RESP_OKAY, 1'b0, 4'h2, "t5_b0");
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("t5_hold%0d_valid", j),
          64'(bus.axi_r_valid_o), 64'd1);
      chk($sformatf("t5_hold%0d_data", j),
          bus.axi_r_data_o, 64'h1);
      chk($sformatf("t5_hold%0d_last", j),
          64'(bus.axi_r_last_o), 64'd0);
    end
    @(posedge clk); #1;
    aw_send(32'h8000_0600, 4'h3, 8'd1, 3'd3, BURST_INCR);
    r_get(64'h1, RESP_OKAY, 1'b0, 4'h2, "t5_b1");
    @(negedge clk);
    chk("t5_b2_valid", 64'(bus.axi_r_valid_o), 64'd1);
    chk("t5_b2_data", bus.axi_r_data_o, 64'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_r_valid", 64'(bus.axi_r_valid_o), 64'd0);
    chk("t5_rst_ar_ready", 64'(bus.axi_ar_ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_r_valid", 64'(bus.axi_r_valid_o), 64'd0);
    chk("t5_post_ar_ready", 64'(bus.axi_ar_ready_o), 64'd1);
    chk("t5_post_aw_ready", 64'(bus.axi_aw_ready_o), 64'd1);
    chk("t5_post_w_ready", 64'(bus.axi_w_ready_o), 64'd0);
    @(posedge clk); #1;

    // Same-cycle AR and AW to one word: read sees old value
    wr_single(32'h8000_0500, 4'h4, 64'd5, 8'hFF, BURST_INCR, 3'd3,
              RESP_OKAY, "t6_pre");
    bus.axi_ar_valid_i = 1'b1; bus.axi_ar_addr_i = 32'h8000_0500;
    bus.axi_ar_id_i = 4'h6; bus.axi_ar_len_i = 8'd0;
    bus.axi_ar_size_i = 3'd3; bus.axi_ar_burst_i = BURST_INCR;
    bus.axi_aw_valid_i = 1'b1; bus.axi_aw_addr_i = 32'h8000_0500;
    bus.axi_aw_id_i = 4'h7; bus.axi_aw_len_i = 8'd0;
    bus.axi_aw_size_i = 3'd3; bus.axi_aw_burst_i = BURST_INCR;
    @(negedge clk);
    chk("t6_ar_ready", 64'(bus.axi_ar_ready_o), 64'd1);
    chk("t6_aw_ready", 64'(bus.axi_aw_ready_o), 64'd1);
    @(posedge clk); #1;
    bus.axi_ar_valid_i = 1'b0;
    bus.axi_aw_valid_i = 1'b0;
    bus.axi_w_valid_i = 1'b1; bus.axi_w_data_i = 64'd9;
    bus.axi_w_strb_i = 8'hFF; bus.axi_w_last_i = 1'b1;
    bus.axi_r_ready_i = 1'b1;
    @(negedge clk);
    chk("t6_r_valid", 64'(bus.axi_r_valid_o), 64'd1);
    chk("t6_w_ready", 64'(bus.axi_w_ready_o), 64'd1);
    chk("t6_old_data", bus.axi_r_data_o, 64'd5);
    @(posedge clk); #1;
    bus.axi_w_valid_i = 1'b0;
    bus.axi_r_ready_i = 1'b0;
    b_get(RESP_OKAY, 4'h7, "t6_w");
    rd_single(32'h8000_0500, 4'hD, 64'd9, RESP_OKAY, "t6_new");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
